mem_arbiter: RTL and testbench

Arbitrates line-granular miss traffic from the instruction cache and the data cache onto the single physical-memory burst port. The caches sit between it and the pipelined datapath, and the datapath stalls on each cache's resp. The block holds one outstanding transaction at a time. Data accesses have priority, and a bounded streak counter guarantees instruction fetch forward progress.

---
 rtl/mem_arbiter_pkg.sv | 23 ++
 rtl/mem_arbiter.sv | 135 +++++++++++++
 tb/tb_mem_arbiter.sv | 365 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared arbiter state/grant types and the cacheline geometry used by the caches.
package mem_arbiter_pkg;

    localparam int ARB_ADDR_BITS    = 32;
    localparam int ARB_LINE_BITS    = 256;
    localparam int ARB_OFFSET_BITS  = $clog2(ARB_LINE_BITS / 8);
    localparam int ARB_D_STREAK_MAX = 4;

    typedef enum logic [2:0] {
        IDLE,
        SERVE_I,
        SERVE_D,
        DONE_I,
        DONE_D
    } arb_state_t;

    typedef enum logic [1:0] {
        GRANT_NONE,
        GRANT_I,
        GRANT_D
    } arb_grant_t;

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates I-cache and D-cache line misses onto one physical-memory burst port,
// one transaction at a time, D first with a bounded streak so I fetch keeps progressing.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_BITS    = ARB_ADDR_BITS,
    parameter int LINE_BITS    = ARB_LINE_BITS,
    parameter int OFFSET_BITS  = ARB_OFFSET_BITS,
    parameter int D_STREAK_MAX = ARB_D_STREAK_MAX
) (
    input  logic                 clk,
    input  logic                 rst,

    input  logic                 icache_read,
    input  logic [ADDR_BITS-1:0] icache_address,
    output logic [LINE_BITS-1:0] icache_rdata,
    output logic                 icache_resp,

    input  logic                 dcache_read,
    input  logic                 dcache_write,
    input  logic [ADDR_BITS-1:0] dcache_address,
    input  logic [LINE_BITS-1:0] dcache_wdata,
    output logic [LINE_BITS-1:0] dcache_rdata,
    output logic                 dcache_resp,

    output logic                 pmem_read,
    output logic                 pmem_write,
    output logic [ADDR_BITS-1:0] pmem_address,
    output logic [LINE_BITS-1:0] pmem_wdata,
    input  logic [LINE_BITS-1:0] pmem_rdata,
    input  logic                 pmem_resp
);

    // state   | meaning
    // IDLE    | no transaction; arbitrate pending requests
    // SERVE_x | pmem request for client x held until pmem_resp
    // DONE_x  | x_resp pulse cycle; incoming requests ignored

    localparam int STREAK_BITS = $clog2(D_STREAK_MAX + 1);
    localparam logic [STREAK_BITS-1:0] STREAK_SAT = STREAK_BITS'(D_STREAK_MAX);
    localparam logic [ADDR_BITS-1:0] LINE_MASK =
        {{(ADDR_BITS - OFFSET_BITS){1'b1}}, {OFFSET_BITS{1'b0}}};

    arb_state_t             state;
    arb_grant_t             grant;
    logic [STREAK_BITS-1:0] streak;
    logic [STREAK_BITS-1:0] streak_next;
    logic                   d_req;
    logic                   forced_i;

    always_comb begin
        d_req       = dcache_read | dcache_write;
        forced_i    = icache_read && (streak == STREAK_SAT);
        grant       = GRANT_NONE;
        streak_next = streak;
        if (state == IDLE) begin
            if (d_req && !forced_i) begin
                grant = GRANT_D;
                if (!icache_read)
                    streak_next = '0;
                else if (streak != STREAK_SAT)
                    streak_next = streak + 1'b1;
            end else if (icache_read) begin
                grant       = GRANT_I;
                streak_next = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            streak       <= '0;
            pmem_read    <= 1'b0;
            pmem_write   <= 1'b0;
            pmem_address <= '0;
            pmem_wdata   <= '0;
            icache_rdata <= '0;
            icache_resp  <= 1'b0;
            dcache_rdata <= '0;
            dcache_resp  <= 1'b0;
        end else begin
            streak <= streak_next;
            case (state)
                IDLE: begin
                    if (grant == GRANT_D) begin
                        state        <= SERVE_D;
                        // read+write together is serviced as a writeback
                        pmem_read    <= ~dcache_write;
                        pmem_write   <= dcache_write;
                        pmem_address <= dcache_address & LINE_MASK;
                        pmem_wdata   <= dcache_wdata;
                    end else if (grant == GRANT_I) begin
                        state        <= SERVE_I;
                        pmem_read    <= 1'b1;
                        pmem_write   <= 1'b0;
                        pmem_address <= icache_address & LINE_MASK;
                    end
                end
                SERVE_I: begin
                    if (pmem_resp) begin
                        state        <= DONE_I;
                        pmem_read    <= 1'b0;
                        pmem_write   <= 1'b0;
                        icache_rdata <= pmem_rdata;
                        icache_resp  <= 1'b1;
                    end
                end
                SERVE_D: begin
                    if (pmem_resp) begin
                        state        <= DONE_D;
                        pmem_read    <= 1'b0;
                        pmem_write   <= 1'b0;
                        dcache_rdata <= pmem_rdata;
                        dcache_resp  <= 1'b1;
                    end
                end
                DONE_I: begin
                    state       <= IDLE;
                    icache_resp <= 1'b0;
                end
                DONE_D: begin
                    state       <= IDLE;
                    dcache_resp <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    a_no_rw_collision: assert property (@(posedge clk) disable iff (!rst)
        !(dcache_read && dcache_write))
        else $warning("mem_arbiter: dcache_read and dcache_write both high, serviced as writeback");

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed vector table, hand-written multi-cycle sequences,
// then randomized client/memory traffic checked against a transaction-level model.
module tb_mem_arbiter;

    localparam int AW          = 32;
    localparam int LW          = 256;
    localparam int SMAX        = 4;
    localparam int RAND_CYCLES = 4000;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          icache_read = 1'b0;
    logic [AW-1:0] icache_address = '0;
    logic [LW-1:0] icache_rdata;
    logic          icache_resp;
    logic          dcache_read = 1'b0;
    logic          dcache_write = 1'b0;
    logic [AW-1:0] dcache_address = '0;
    logic [LW-1:0] dcache_wdata = '0;
    logic [LW-1:0] dcache_rdata;
    logic          dcache_resp;
    logic          pmem_read;
    logic          pmem_write;
    logic [AW-1:0] pmem_address;
    logic [LW-1:0] pmem_wdata;
    logic [LW-1:0] pmem_rdata = '0;
    logic          pmem_resp = 1'b0;

    int checks = 0;
    int passed = 0;
    logic [LW-1:0] exp_irdata = '0;
    logic [LW-1:0] exp_drdata = '0;

    typedef struct {
        logic          is_d;
        logic          wr;
        logic [AW-1:0] addr;
        logic [LW-1:0] wdata;
        logic [LW-1:0] rdata;
        int            lat;
        logic [AW-1:0] exp_addr;
    } vec_t;

    vec_t vecs[5];

    mem_arbiter dut (
        .clk            (clk),
        .rst            (rst),
        .icache_read    (icache_read),
        .icache_address (icache_address),
        .icache_rdata   (icache_rdata),
        .icache_resp    (icache_resp),
        .dcache_read    (dcache_read),
        .dcache_write   (dcache_write),
        .dcache_address (dcache_address),
        .dcache_wdata   (dcache_wdata),
        .dcache_rdata   (dcache_rdata),
        .dcache_resp    (dcache_resp),
        .pmem_read      (pmem_read),
        .pmem_write     (pmem_write),
        .pmem_address   (pmem_address),
        .pmem_wdata     (pmem_wdata),
        .pmem_rdata     (pmem_rdata),
        .pmem_resp      (pmem_resp)
    );

    always #5 clk = ~clk;

    function automatic logic [LW-1:0] rand_line();
        logic [LW-1:0] v;
        v = '0;
        for (int i = 0; i < LW / 32; i++) v[i*32 +: 32] = $urandom();
        return v;
    endfunction

    task automatic check_b(input string name, input logic act, input logic exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %b expected %b", name, act, exp);
    endtask

    task automatic check_a(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic check_l(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic check_zero(input string tag);
        check_b({tag, "_pmem_read"}, pmem_read, 1'b0);
        check_b({tag, "_pmem_write"}, pmem_write, 1'b0);
        check_a({tag, "_pmem_address"}, pmem_address, '0);
        check_l({tag, "_pmem_wdata"}, pmem_wdata, '0);
        check_b({tag, "_icache_resp"}, icache_resp, 1'b0);
        check_b({tag, "_dcache_resp"}, dcache_resp, 1'b0);
        check_l({tag, "_icache_rdata"}, icache_rdata, '0);
        check_l({tag, "_dcache_rdata"}, dcache_rdata, '0);
    endtask

    task automatic check_quiet(input string tag);
        check_b({tag, "_pmem_read"}, pmem_read, 1'b0);
        check_b({tag, "_pmem_write"}, pmem_write, 1'b0);
        check_b({tag, "_icache_resp"}, icache_resp, 1'b0);
        check_b({tag, "_dcache_resp"}, dcache_resp, 1'b0);
    endtask

    // Called at the first negedge the pmem request must be visible; returns in the resp cycle.
    task automatic serve(input string tag, input logic to_d, input logic wr,
                         input logic [AW-1:0] a, input logic [LW-1:0] wd,
                         input int lat, input logic [LW-1:0] rd);
        for (int c = 0; c < lat; c++) begin
            check_b({tag, "_pmem_read"}, pmem_read, !wr);
            check_b({tag, "_pmem_write"}, pmem_write, wr);
            check_a({tag, "_pmem_address"}, pmem_address, a);
            if (wr) check_l({tag, "_pmem_wdata"}, pmem_wdata, wd);
            check_b({tag, "_early_resp"}, icache_resp | dcache_resp, 1'b0);
            if (c == lat - 1) begin
                pmem_resp  = 1'b1;
                pmem_rdata = rd;
            end
            @(negedge clk);
        end
        pmem_resp  = 1'b0;
        pmem_rdata = ~rd;
        if (to_d) exp_drdata = rd;
        else      exp_irdata = rd;
        check_b({tag, "_icache_resp"}, icache_resp, !to_d);
        check_b({tag, "_dcache_resp"}, dcache_resp, to_d);
        check_b({tag, "_done_pmem_read"}, pmem_read, 1'b0);
        check_b({tag, "_done_pmem_write"}, pmem_write, 1'b0);
        check_l({tag, "_icache_rdata"}, icache_rdata, exp_irdata);
        check_l({tag, "_dcache_rdata"}, dcache_rdata, exp_drdata);
    endtask

    initial begin
        logic [LW-1:0] w;
        logic          d_pend;
        int            streak_m;
        int            grant_edge;
        int            resp_edge;
        logic          act;
        logic          t_d;
        logic          t_wr;
        logic [AW-1:0] t_addr;
        logic [LW-1:0] t_wd;
        logic [LW-1:0] t_rd;
        logic          e_rd;
        logic          e_wr;
        logic          e_ir;
        logic          e_dr;
        logic [AW-1:0] e_addr;
        logic [LW-1:0] e_wd;

        vecs[0] = '{is_d: 1'b0, wr: 1'b0, addr: 32'h0000_1234, wdata: '0,
                    rdata: {32{8'hA5}}, lat: 1, exp_addr: 32'h0000_1220};
        vecs[1] = '{is_d: 1'b1, wr: 1'b1, addr: 32'h8000_0040, wdata: {8{32'hDEAD_BEEF}},
                    rdata: '0, lat: 10, exp_addr: 32'h8000_0040};
        vecs[2] = '{is_d: 1'b1, wr: 1'b0, addr: 32'h0000_003F, wdata: {8{32'h5555_AAAA}},
                    rdata: {8{32'h1234_5678}}, lat: 3, exp_addr: 32'h0000_0020};
        vecs[3] = '{is_d: 1'b0, wr: 1'b0, addr: 32'hFFFF_FFFF, wdata: '0,
                    rdata: {4{64'h0123_4567_89AB_CDEF}}, lat: 2, exp_addr: 32'hFFFF_FFE0};
        vecs[4] = '{is_d: 1'b1, wr: 1'b1, addr: 32'h7654_321F, wdata: {16{16'hC3C3}},
                    rdata: '0, lat: 1, exp_addr: 32'h7654_3200};

        rst = 1'b0;
        repeat (2) @(negedge clk);
        check_zero("reset");
        rst = 1'b1;

        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (vecs[i].is_d) begin
                dcache_read    = !vecs[i].wr;
                dcache_write   = vecs[i].wr;
                dcache_address = vecs[i].addr;
                dcache_wdata   = vecs[i].wdata;
            end else begin
                icache_read    = 1'b1;
                icache_address = vecs[i].addr;
            end
            @(negedge clk);
            serve($sformatf("vec%0d", i), vecs[i].is_d, vecs[i].wr, vecs[i].exp_addr,
                  vecs[i].wdata, vecs[i].lat, vecs[i].rdata);
            icache_read  = 1'b0;
            dcache_read  = 1'b0;
            dcache_write = 1'b0;
            @(negedge clk);
            check_quiet($sformatf("vec%0d_after", i));
        end

        // Contention: D first, then I after exactly the DONE_D and IDLE cycles.
        @(negedge clk);
        icache_read = 1'b1; icache_address = 32'h0000_4444;
        dcache_read = 1'b1; dcache_address = 32'h0000_8888;
        @(negedge clk);
        serve("cont_d", 1'b1, 1'b0, 32'h0000_8880, '0, 2, rand_line());
        dcache_read = 1'b0;
        @(negedge clk);
        check_quiet("cont_gap");
        @(negedge clk);
        serve("cont_i", 1'b0, 1'b0, 32'h0000_4440, '0, 3, rand_line());
        icache_read = 1'b0;
        @(negedge clk);
        check_quiet("cont_end");

        // Fairness: D held continuously while I waits.
        icache_read = 1'b1; icache_address = 32'h0001_0000;
        dcache_read = 1'b1; dcache_address = 32'h0002_0000;
        @(negedge clk);
        for (int r = 0; r < SMAX; r++) begin
            serve($sformatf("fair_d%0d", r), 1'b1, 1'b0, 32'h0002_0000 + 32'(r * 32), '0, 1, rand_line());
            dcache_address = 32'h0002_0000 + 32'((r + 1) * 32);
            @(negedge clk);
            check_quiet($sformatf("fair_gap%0d", r));
            @(negedge clk);
        end
        serve("fair_i", 1'b0, 1'b0, 32'h0001_0000, '0, 1, rand_line());
        icache_address = 32'h0001_1000;
        @(negedge clk);
        check_quiet("fair_gap_i");
        @(negedge clk);
        serve("fair_streak_clr", 1'b1, 1'b0, 32'h0002_0000 + 32'(SMAX * 32), '0, 1, rand_line());
        icache_read = 1'b0;
        dcache_read = 1'b0;
        @(negedge clk);
        check_quiet("fair_end");
        @(negedge clk);
        check_quiet("fair_dropped_i");

        // Reset in the middle of a write with pmem_resp already pending.
        dcache_write = 1'b1; dcache_address = 32'h0003_0040; dcache_wdata = rand_line();
        @(negedge clk);
        check_b("rstmid_pmem_write", pmem_write, 1'b1);
        @(negedge clk);
        pmem_resp  = 1'b1;
        pmem_rdata = rand_line();
        #2 rst = 1'b0;
        #1 check_zero("rst_async");
        exp_irdata = '0;
        exp_drdata = '0;
        pmem_resp    = 1'b0;
        dcache_write = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_quiet("rst_release");
        icache_read = 1'b1; icache_address = 32'h0000_5678;
        @(negedge clk);
        serve("rst_after_i", 1'b0, 1'b0, 32'h0000_5660, '0, 2, rand_line());
        icache_read = 1'b0;
        @(negedge clk);
        check_quiet("rst_after_end");

        // Read and write together: serviced as one writeback.
        w = rand_line();
        dcache_read = 1'b1; dcache_write = 1'b1;
        dcache_address = 32'h0004_0080; dcache_wdata = w;
        @(negedge clk);
        serve("proto", 1'b1, 1'b1, 32'h0004_0080, w, 3, rand_line());
        dcache_read  = 1'b0;
        dcache_write = 1'b0;
        @(negedge clk);
        check_quiet("proto_end");

        // Randomized traffic against a transaction-level model.
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        exp_irdata = '0;
        exp_drdata = '0;
        streak_m   = 0;
        grant_edge = 1;
        resp_edge  = 0;
        act        = 1'b0;
        t_d = 1'b0; t_wr = 1'b0; t_addr = '0; t_wd = '0; t_rd = '0;
        e_rd = 1'b0; e_wr = 1'b0; e_ir = 1'b0; e_dr = 1'b0; e_addr = '0; e_wd = '0;
        for (int k = 0; k < RAND_CYCLES; k++) begin
            check_b("rnd_pmem_read", pmem_read, e_rd);
            check_b("rnd_pmem_write", pmem_write, e_wr);
            if (e_rd || e_wr) check_a("rnd_pmem_address", pmem_address, e_addr);
            if (e_wr) check_l("rnd_pmem_wdata", pmem_wdata, e_wd);
            check_b("rnd_icache_resp", icache_resp, e_ir);
            check_b("rnd_dcache_resp", dcache_resp, e_dr);
            check_l("rnd_icache_rdata", icache_rdata, exp_irdata);
            check_l("rnd_dcache_rdata", dcache_rdata, exp_drdata);

            if (e_ir) begin
                icache_read    = ($urandom_range(0, 1) == 1);
                icache_address = $urandom();
            end else if (!icache_read) begin
                if ($urandom_range(0, 2) == 0) begin
                    icache_read    = 1'b1;
                    icache_address = $urandom();
                end
            end else if ($urandom_range(0, 3) == 0) begin
                icache_address = $urandom();
            end

            if (e_dr || !(dcache_read || dcache_write)) begin
                if ((e_dr && $urandom_range(0, 1) == 1) || (!e_dr && $urandom_range(0, 2) == 0)) begin
                    dcache_write   = ($urandom_range(0, 1) == 1);
                    dcache_read    = !dcache_write;
                    dcache_address = $urandom();
                    dcache_wdata   = rand_line();
                end else begin
                    dcache_read  = 1'b0;
                    dcache_write = 1'b0;
                end
            end else if ($urandom_range(0, 3) == 0) begin
                dcache_address = $urandom();
            end

            e_ir = 1'b0;
            e_dr = 1'b0;
            if (act && (k + 1 == resp_edge)) begin
                pmem_resp  = 1'b1;
                pmem_rdata = t_rd;
                e_rd = 1'b0;
                e_wr = 1'b0;
                act  = 1'b0;
                if (t_d) begin e_dr = 1'b1; exp_drdata = t_rd; end
                else     begin e_ir = 1'b1; exp_irdata = t_rd; end
                grant_edge = k + 3;
            end else begin
                pmem_resp  = 1'b0;
                pmem_rdata = rand_line();
                if (!act && (k + 1 >= grant_edge)) begin
                    d_pend = dcache_read || dcache_write;
                    if (d_pend && !(icache_read && streak_m == SMAX)) begin
                        act    = 1'b1;
                        t_d    = 1'b1;
                        t_wr   = dcache_write;
                        t_addr = (dcache_address / 32) * 32;
                        t_wd   = dcache_wdata;
                        streak_m = icache_read ? ((streak_m < SMAX) ? streak_m + 1 : SMAX) : 0;
                    end else if (icache_read) begin
                        act    = 1'b1;
                        t_d    = 1'b0;
                        t_wr   = 1'b0;
                        t_addr = (icache_address / 32) * 32;
                        streak_m = 0;
                    end
                    if (act) begin
                        t_rd      = rand_line();
                        resp_edge = k + 1 + $urandom_range(1, 6);
                        e_rd      = !t_wr;
                        e_wr      = t_wr;
                        e_addr    = t_addr;
                        e_wd      = t_wd;
                    end
                end
            end
            @(negedge clk);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
